// File: rtl/exe_muldiv.sv
// EXE-stage iterative multiply/divide unit with architectural HI/LO.
// Also services MFHI/MFLO/MTHI/MTLO and registers the move-from result for EXE/MEM.
module exe_muldiv #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_in,
    input  logic [WIDTH-1:0] pc_in,
    input  logic [WIDTH-1:0] instruction_in,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    input  logic             flush,
    output logic             stall_req,
    output logic [WIDTH-1:0] result,
    output logic             result_valid,
    output logic [WIDTH-1:0] pc_out,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_DIVU  = 6'h1B;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t state, state_next;

    logic [CW-1:0]      count;
    logic               is_rtype, is_muldiv, start, accept_mv;
    logic [5:0]         funct;
    logic               sign_a, sign_b;
    logic [WIDTH-1:0]   mag_a, mag_b;

    logic               op_div, neg_res, neg_rem, div_zero;
    logic [WIDTH-1:0]   op_a, acc_hi, acc_lo;

    logic [WIDTH:0]     mul_sum, div_shift, div_diff;
    logic               div_ge;
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    always_comb begin
        is_rtype  = (instruction_in[31:26] == 6'd0);
        funct     = instruction_in[5:0];
        is_muldiv = is_rtype && (funct >= F_MULT) && (funct <= F_DIVU);
        start     = (state == IDLE) && valid_in && is_muldiv && !flush;
        accept_mv = (state == IDLE) && valid_in && is_rtype && !flush && !start;

        // funct[0] clear selects the signed variants (MULT/DIV)
        sign_a = !funct[0] && rs_data[WIDTH-1];
        sign_b = !funct[0] && rt_data[WIDTH-1];
        mag_a  = sign_a ? ('0 - rs_data) : rs_data;
        mag_b  = sign_b ? ('0 - rt_data) : rt_data;
    end

    always_comb begin
        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, op_a} : '0);
        div_shift = {acc_hi, acc_lo[WIDTH-1]};
        div_diff  = div_shift - {1'b0, op_a};
        div_ge    = (div_shift >= {1'b0, op_a});

        prod     = {acc_hi, acc_lo};
        prod_fix = neg_res ? ('0 - prod) : prod;
        // a zero divisor yields an all-ones quotient regardless of sign handling
        quo_fix  = div_zero ? '1 : (neg_res ? ('0 - acc_lo) : acc_lo);
        rem_fix  = neg_rem ? ('0 - acc_hi) : acc_hi;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = BUSY;
            BUSY:    if (flush) state_next = IDLE;
                     else if (count == LAST) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        stall_req = start || (state == BUSY);
        busy      = (state != IDLE);
    end

    // Iteration datapath: acc_hi/acc_lo form the product (multiply) or remainder/quotient (divide)
    always_ff @(posedge clk) begin
        if (start) begin
            op_div   <= funct[1];
            neg_res  <= sign_a ^ sign_b;
            neg_rem  <= sign_a;
            div_zero <= funct[1] && (rt_data == '0);
            acc_hi   <= '0;
            op_a     <= funct[1] ? mag_b : mag_a;
            acc_lo   <= funct[1] ? mag_a : mag_b;
        end else if (state == BUSY) begin
            if (op_div) begin
                acc_hi <= div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
                acc_lo <= {acc_lo[WIDTH-2:0], div_ge};
            end else begin
                acc_hi <= mul_sum[WIDTH:1];
                acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count        <= '0;
            hi           <= '0;
            lo           <= '0;
            result       <= '0;
            result_valid <= 1'b0;
            pc_out       <= '0;
        end else begin
            result_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        count <= '0;
                    end else if (accept_mv) begin
                        case (funct)
                            F_MFHI: begin
                                result       <= hi;
                                result_valid <= 1'b1;
                                pc_out       <= pc_in;
                            end
                            F_MFLO: begin
                                result       <= lo;
                                result_valid <= 1'b1;
                                pc_out       <= pc_in;
                            end
                            F_MTHI:  hi <= rs_data;
                            F_MTLO:  lo <= rs_data;
                            default: ;
                        endcase
                    end
                end
                BUSY: if (!flush) count <= count + 1'b1;
                DONE: begin
                    if (!flush) begin
                        if (op_div) begin
                            hi <= rem_fix;
                            lo <= quo_fix;
                        end else begin
                            hi <= prod_fix[2*WIDTH-1:WIDTH];
                            lo <= prod_fix[WIDTH-1:0];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_exe_muldiv.sv
// Scoreboard bench for exe_muldiv: move-from results are queued at issue and
// checked by an independent monitor whenever result_valid is presented.
module tb_exe_muldiv;

    localparam int unsigned W = 32;
    localparam logic [5:0] F_MFHI = 6'h10, F_MTHI = 6'h11, F_MFLO = 6'h12, F_MTLO = 6'h13;
    localparam logic [5:0] F_MULT = 6'h18, F_MULTU = 6'h19, F_DIV = 6'h1A, F_DIVU = 6'h1B;

    logic         clk = 1'b0;
    logic         rst, valid_in, flush;
    logic [W-1:0] pc_in, instruction_in, rs_data, rt_data;
    logic         stall_req, result_valid, busy;
    logic [W-1:0] result, pc_out, hi, lo;

    int n_checks = 0;
    int n_fail   = 0;
    logic [63:0] exp_q[$];

    exe_muldiv #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .pc_in(pc_in),
        .instruction_in(instruction_in), .rs_data(rs_data), .rt_data(rt_data),
        .flush(flush), .stall_req(stall_req), .result(result),
        .result_valid(result_valid), .pc_out(pc_out), .hi(hi), .lo(lo), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every presented result must match the oldest queued expectation
    always @(negedge clk) begin
        if (!rst && result_valid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_result: got result=%h pc=%h expected none", result, pc_out);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                check("result", result, e[63:32]);
                check("pc_out", pc_out, e[31:0]);
            end
        end
    end

    function automatic logic [31:0] rtype(input logic [5:0] f);
        return {26'd0, f};
    endfunction

    task automatic present(input logic [5:0] f, input logic [31:0] pc, input logic [31:0] a,
                           input logic [31:0] b);
        valid_in = 1'b1;
        instruction_in = rtype(f);
        pc_in = pc;
        rs_data = a;
        rt_data = b;
    endtask

    // Hold the instruction until stall drops (DONE cycle); optionally flush in DONE
    task automatic run_op(input logic [5:0] f, input logic [31:0] pc, input logic [31:0] a,
                          input logic [31:0] b, input bit kill_in_done);
        int cnt;
        cnt = 0;
        present(f, pc, a, b);
        for (int g = 0; g < 100; g++) begin
            @(negedge clk);
            if (!stall_req) break;
            cnt++;
        end
        check("stall_cycles", 32'(cnt), 32'd33);
        if (kill_in_done) flush = 1'b1;
        @(posedge clk); #1;
        valid_in = 1'b0;
        flush = 1'b0;
    endtask

    task automatic mf(input logic [5:0] f, input logic [31:0] pc, input logic [31:0] exp);
        present(f, pc, 32'd0, 32'd0);
        exp_q.push_back({exp, pc});
        @(posedge clk); #1;
        valid_in = 1'b0;
    endtask

    task automatic mt(input logic [5:0] f, input logic [31:0] val);
        present(f, 32'h0, val, 32'd0);
        @(posedge clk); #1;
        valid_in = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; valid_in = 1'b0; flush = 1'b0;
        pc_in = '0; instruction_in = '0; rs_data = '0; rt_data = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_hi", hi, 32'h0);
        check("reset_lo", lo, 32'h0);
        check("reset_result", result, 32'h0);
        check("reset_pc_out", pc_out, 32'h0);
        check("reset_flags", {29'd0, result_valid, stall_req, busy}, 32'h0);
        @(posedge clk); #1;

        run_op(F_MULT, 32'h100, 32'hFFFFFFFF, 32'h2, 1'b0);
        @(negedge clk);
        check("mult_hi", hi, 32'hFFFFFFFF);
        check("mult_lo", lo, 32'hFFFFFFFE);
        @(posedge clk); #1;
        mf(F_MFHI, 32'h104, 32'hFFFFFFFF);
        mf(F_MFLO, 32'h108, 32'hFFFFFFFE);

        run_op(F_MULTU, 32'h200, 32'hFFFFFFFF, 32'h2, 1'b0);
        mf(F_MFHI, 32'h204, 32'h00000001);
        mf(F_MFLO, 32'h208, 32'hFFFFFFFE);

        run_op(F_DIV, 32'h300, 32'hFFFFFFF9, 32'h2, 1'b0);
        mf(F_MFLO, 32'h304, 32'hFFFFFFFD);
        mf(F_MFHI, 32'h308, 32'hFFFFFFFF);

        run_op(F_DIV, 32'h400, 32'h80000000, 32'hFFFFFFFF, 1'b0);
        mf(F_MFLO, 32'h404, 32'h80000000);
        mf(F_MFHI, 32'h408, 32'h00000000);

        run_op(F_DIVU, 32'h500, 32'h64, 32'h0, 1'b0);
        mf(F_MFHI, 32'h504, 32'h00000064);
        mf(F_MFLO, 32'h508, 32'hFFFFFFFF);

        run_op(F_DIV, 32'h600, 32'hFFFFFFF0, 32'h0, 1'b0);
        mf(F_MFHI, 32'h604, 32'hFFFFFFF0);
        mf(F_MFLO, 32'h608, 32'hFFFFFFFF);

        // Flush during BUSY at count 10
        mt(F_MTHI, 32'h12345678);
        mt(F_MTLO, 32'h12345678);
        present(F_DIVU, 32'h700, 32'd100, 32'd7);
        @(posedge clk); #1;
        valid_in = 1'b0;
        repeat (10) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        check("flush_busy", {31'd0, busy}, 32'd0);
        check("flush_stall", {31'd0, stall_req}, 32'd0);
        check("flush_hi", hi, 32'h12345678);
        check("flush_lo", lo, 32'h12345678);
        @(posedge clk); #1;
        mf(F_MFLO, 32'h70C, 32'h12345678);

        // Reset in the middle of an operation
        present(F_DIVU, 32'h800, 32'd100, 32'd7);
        @(posedge clk); #1;
        valid_in = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid_hi", hi, 32'h0);
        check("rst_mid_lo", lo, 32'h0);
        check("rst_mid_busy", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;

        // MTLO then MFLO back-to-back, then a flushed MFLO
        mt(F_MTLO, 32'hA5A5A5A5);
        mf(F_MFLO, 32'h900, 32'hA5A5A5A5);
        present(F_MFLO, 32'h904, 32'd0, 32'd0);
        flush = 1'b1;
        @(posedge clk); #1;
        valid_in = 1'b0;
        flush = 1'b0;
        @(negedge clk);
        check("flushed_mf_valid", {31'd0, result_valid}, 32'd0);
        check("flushed_mf_hold", result, 32'hA5A5A5A5);
        @(posedge clk); #1;

        // Flush in DONE beats the hi/lo write
        run_op(F_MULTU, 32'hA00, 32'd3, 32'd5, 1'b1);
        @(negedge clk);
        check("done_flush_hi", hi, 32'h0);
        check("done_flush_lo", lo, 32'hA5A5A5A5);
        check("done_flush_busy", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;

        run_op(F_MULTU, 32'hB00, 32'd3, 32'd5, 1'b0);
        mf(F_MFLO, 32'hB04, 32'h0000000F);
        mf(F_MFHI, 32'hB08, 32'h00000000);

        repeat (4) @(posedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
